// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared defaults and helpers for the memory bus crossbar.
//   DefNrDevices / DefNrHosts / DefDataWidth / DefAddressWidth : default sizes
//   resp_kind_e : what the registered response stage returns next cycle
//   idx_width() : width of a binary index over n ports ($clog2, minimum 1)
package mem_bus_pkg;

    localparam int unsigned DefNrDevices    = 4;
    localparam int unsigned DefNrHosts      = 2;
    localparam int unsigned DefDataWidth    = 32;
    localparam int unsigned DefAddressWidth = 32;

    // Response kind captured on a grant; RespNone doubles as "nothing pending".
    typedef enum logic [1:0] {
        RespNone     = 2'd0,
        RespDevice   = 2'd1,
        RespUnmapped = 2'd2
    } resp_kind_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_xbar_if.sv
// mem_bus_xbar_if: host-side and device-side request/grant/rvalid bus bundle.
//   host_*   : NrHosts request ports (req/addr/we/be/wdata in, gnt/rvalid/rdata/err out)
//   device_* : NrDevices device ports (req/addr/we/be/wdata out, rvalid/rdata/err in)
//   modport master : hosts and devices (the environment around the crossbar)
//   modport slave  : the crossbar itself
interface mem_bus_xbar_if import mem_bus_pkg::*; #(
    parameter int unsigned NrDevices    = DefNrDevices,
    parameter int unsigned NrHosts      = DefNrHosts,
    parameter int unsigned DataWidth    = DefDataWidth,
    parameter int unsigned AddressWidth = DefAddressWidth
);

    logic [NrHosts-1:0]                     host_req;
    logic [NrHosts-1:0]                     host_gnt;
    logic [NrHosts-1:0][AddressWidth-1:0]   host_addr;
    logic [NrHosts-1:0]                     host_we;
    logic [NrHosts-1:0][DataWidth/8-1:0]    host_be;
    logic [NrHosts-1:0][DataWidth-1:0]      host_wdata;
    logic [NrHosts-1:0]                     host_rvalid;
    logic [NrHosts-1:0][DataWidth-1:0]      host_rdata;
    logic [NrHosts-1:0]                     host_err;

    logic [NrDevices-1:0]                   device_req;
    logic [NrDevices-1:0][AddressWidth-1:0] device_addr;
    logic [NrDevices-1:0]                   device_we;
    logic [NrDevices-1:0][DataWidth/8-1:0]  device_be;
    logic [NrDevices-1:0][DataWidth-1:0]    device_wdata;
    logic [NrDevices-1:0]                   device_rvalid;
    logic [NrDevices-1:0][DataWidth-1:0]    device_rdata;
    logic [NrDevices-1:0]                   device_err;

    modport master (
        output host_req, host_addr, host_we, host_be, host_wdata,
        input  host_gnt, host_rvalid, host_rdata, host_err,
        input  device_req, device_addr, device_we, device_be, device_wdata,
        output device_rvalid, device_rdata, device_err
    );

    modport slave (
        input  host_req, host_addr, host_we, host_be, host_wdata,
        output host_gnt, host_rvalid, host_rdata, host_err,
        output device_req, device_addr, device_we, device_be, device_wdata,
        input  device_rvalid, device_rdata, device_err
    );

endinterface

// File: rtl/mem_bus_prio_arb.sv
// mem_bus_prio_arb: fixed-priority selector, index 0 highest priority.
//   req_i   : request vector
//   gnt_o   : one-hot grant of the lowest-index requester (0 when idle)
//   idx_o   : binary index of that requester (0 when idle)
//   valid_o : at least one request present
module mem_bus_prio_arb import mem_bus_pkg::*; #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = idx_width(N)
) (
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        // Isolate the lowest set bit.
        gnt_o   = req_i & ~(req_i - N'(1));
        // Walk downward so the lowest requesting index is assigned last.
        for (int unsigned i = N; i > 0; i--) begin
            if (req_i[i-1]) begin
                idx_o = IdxW'(i - 1);
            end
        end
    end

endmodule

// File: rtl/mem_bus_xbar.sv
// mem_bus_xbar: shared-bus interconnect, NrHosts hosts to NrDevices devices.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   bus (slave)           : host request/response ports and device ports
//   cfg_device_addr_base  : per-device region base
//   cfg_device_addr_mask  : per-device region mask; device d hits when
//                           (addr & mask[d]) == base[d], lowest index wins
// Fixed-priority grant and decode are combinational; the response is routed
// back one cycle later from registered host/device selects.
module mem_bus_xbar import mem_bus_pkg::*; #(
    parameter int unsigned NrDevices    = DefNrDevices,
    parameter int unsigned NrHosts      = DefNrHosts,
    parameter int unsigned DataWidth    = DefDataWidth,
    parameter int unsigned AddressWidth = DefAddressWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    mem_bus_xbar_if.slave                       bus,
    input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base,
    input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask
);

    localparam int unsigned HostIdxW = idx_width(NrHosts);
    localparam int unsigned DevIdxW  = idx_width(NrDevices);

    logic [NrHosts-1:0]      host_gnt;
    logic [HostIdxW-1:0]     host_idx;
    logic                    host_any;
    logic [AddressWidth-1:0] win_addr;

    logic [NrDevices-1:0]    dev_match;
    logic [NrDevices-1:0]    dev_oh;
    logic [DevIdxW-1:0]      dev_idx;
    logic                    dev_hit;

    resp_kind_e              resp_q;
    logic [HostIdxW-1:0]     host_sel_q;
    logic [DevIdxW-1:0]      dev_sel_q;

    mem_bus_prio_arb #(.N(NrHosts), .IdxW(HostIdxW)) u_host_arb (
        .req_i   (bus.host_req),
        .gnt_o   (host_gnt),
        .idx_o   (host_idx),
        .valid_o (host_any)
    );

    // Overlapping regions resolve the same way as hosts: lowest index wins.
    mem_bus_prio_arb #(.N(NrDevices), .IdxW(DevIdxW)) u_dev_sel (
        .req_i   (dev_match),
        .gnt_o   (dev_oh),
        .idx_o   (dev_idx),
        .valid_o (dev_hit)
    );

    // host_idx is 0 when nobody requests, so host 0's fields show through.
    always_comb begin
        win_addr = bus.host_addr[host_idx];
        for (int unsigned d = 0; d < NrDevices; d++) begin
            dev_match[d] = (win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d];
        end
    end

    always_comb begin
        bus.host_gnt   = rst_i ? '0 : host_gnt;
        bus.device_req = (rst_i || !host_any) ? '0 : dev_oh;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            bus.device_addr[d]  = win_addr;
            bus.device_we[d]    = bus.host_we[host_idx];
            bus.device_be[d]    = bus.host_be[host_idx];
            bus.device_wdata[d] = bus.host_wdata[host_idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_q     <= RespNone;
            host_sel_q <= '0;
            dev_sel_q  <= '0;
        end else begin
            host_sel_q <= host_idx;
            dev_sel_q  <= dev_idx;
            if (!host_any) begin
                resp_q <= RespNone;
            end else if (dev_hit) begin
                resp_q <= RespDevice;
            end else begin
                resp_q <= RespUnmapped;
            end
        end
    end

    always_comb begin
        bus.host_rvalid = '0;
        bus.host_err    = '0;
        bus.host_rdata  = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (!rst_i && host_sel_q == HostIdxW'(h)) begin
                unique case (resp_q)
                    RespDevice: begin
                        bus.host_rvalid[h] = bus.device_rvalid[dev_sel_q];
                        bus.host_rdata[h]  = bus.device_rdata[dev_sel_q];
                        bus.host_err[h]    = bus.device_err[dev_sel_q];
                    end
                    RespUnmapped: begin
                        bus.host_rvalid[h] = 1'b1;
                        bus.host_err[h]    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_xbar.sv
// tb_mem_bus_xbar: directed scenarios followed by randomized traffic, each
// cycle compared against a reference model of the arbitration, decode and
// one-cycle response rules.
module tb_mem_bus_xbar;

    localparam int NH = 2;
    localparam int ND = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    logic [ND-1:0][AW-1:0] base;
    logic [ND-1:0][AW-1:0] mask;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model: transaction granted in the previous cycle.
    bit prev_valid = 1'b0;
    int prev_host  = -1;
    int prev_dev   = -1;   // -1 means unmapped

    always #5 clk = ~clk;

    mem_bus_xbar_if #(.NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) bus ();

    mem_bus_xbar #(.NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .bus                  (bus),
        .cfg_device_addr_base (base),
        .cfg_device_addr_mask (mask)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_winner(input logic [NH-1:0] req);
        for (int h = 0; h < NH; h++) if (req[h]) return h;
        return -1;
    endfunction

    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int d = 0; d < ND; d++) if ((a & mask[d]) == base[d]) return d;
        return -1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 4);
        if (r < ND) return (base[r] | ($urandom & ~mask[r])) & ~32'h3;
        return 32'h50000 | (AW'($urandom_range(0, 255)) << 2);
    endfunction

    task automatic set_host(input int h, input logic [AW-1:0] a, input logic we,
                            input logic [3:0] be, input logic [DW-1:0] wd);
        bus.host_req[h]   = 1'b1;
        bus.host_addr[h]  = a;
        bus.host_we[h]    = we;
        bus.host_be[h]    = be;
        bus.host_wdata[h] = wd;
    endtask

    // Called at posedge+1 with host inputs already applied. Drives device
    // answers for last cycle's request, checks mid-cycle, advances the model.
    task automatic do_cycle(input string tag, input bit ovr = 1'b0,
                            input logic [DW-1:0] ov_rdata = '0, input logic ov_err = 1'b0);
        int w, d, sel;
        logic [NH-1:0] exp_gnt;
        logic [ND-1:0] exp_dreq;
        logic exp_rv, exp_er;
        logic [DW-1:0] exp_rd;
        for (int k = 0; k < ND; k++) begin
            bus.device_rdata[k]  = $urandom;
            bus.device_err[k]    = 1'($urandom_range(0, 1));
            bus.device_rvalid[k] = 1'b0;
        end
        if (prev_valid && prev_dev >= 0) begin
            bus.device_rvalid[prev_dev] = 1'b1;
            if (ovr) begin
                bus.device_rdata[prev_dev] = ov_rdata;
                bus.device_err[prev_dev]   = ov_err;
            end
        end
        #3;
        w = rst ? -1 : ref_winner(bus.host_req);
        d = (w >= 0) ? ref_decode(bus.host_addr[w]) : -1;
        exp_gnt  = '0;
        exp_dreq = '0;
        if (w >= 0) exp_gnt[w] = 1'b1;
        if (d >= 0) exp_dreq[d] = 1'b1;
        chk({tag, ":gnt"}, DW'(bus.host_gnt), DW'(exp_gnt));
        chk({tag, ":dev_req"}, DW'(bus.device_req), DW'(exp_dreq));
        if (!rst) begin
            sel = (w < 0) ? 0 : w;
            for (int k = 0; k < ND; k++) begin
                chk($sformatf("%s:dev_addr%0d", tag, k), bus.device_addr[k], bus.host_addr[sel]);
            end
            chk({tag, ":dev_we"}, DW'(bus.device_we[ND-1]), DW'(bus.host_we[sel]));
            chk({tag, ":dev_be"}, DW'(bus.device_be[1]), DW'(bus.host_be[sel]));
            chk({tag, ":dev_wdata"}, bus.device_wdata[2], bus.host_wdata[sel]);
        end
        for (int h = 0; h < NH; h++) begin
            exp_rv = 1'b0;
            exp_er = 1'b0;
            exp_rd = '0;
            if (!rst && prev_valid && prev_host == h) begin
                exp_rv = 1'b1;
                if (prev_dev < 0) begin
                    exp_er = 1'b1;
                end else begin
                    exp_er = bus.device_err[prev_dev];
                    exp_rd = bus.device_rdata[prev_dev];
                end
            end
            chk($sformatf("%s:rvalid%0d", tag, h), DW'(bus.host_rvalid[h]), DW'(exp_rv));
            chk($sformatf("%s:err%0d", tag, h), DW'(bus.host_err[h]), DW'(exp_er));
            chk($sformatf("%s:rdata%0d", tag, h), bus.host_rdata[h], exp_rd);
        end
        @(posedge clk);
        prev_valid = (w >= 0);
        prev_host  = w;
        prev_dev   = d;
        #1;
    endtask

    initial begin
        base[0] = 32'h0010_0000; mask[0] = ~32'h000F_FFFF;
        base[1] = 32'h0002_0000; mask[1] = ~32'h0000_03FF;
        base[2] = 32'h0003_0000; mask[2] = ~32'h0000_03FF;
        base[3] = 32'h0004_0000; mask[3] = ~32'h0000_03FF;
        rst = 1'b1;
        bus.device_rvalid = '0;
        bus.device_rdata  = '0;
        bus.device_err    = '0;
        for (int h = 0; h < NH; h++) set_host(h, rand_addr(), 1'b1, 4'hF, $urandom);
        @(posedge clk);
        #1;

        // Reset holds grants and requests low even with hosts requesting.
        do_cycle("reset");
        rst = 1'b0;
        bus.host_req = '0;
        do_cycle("idle");

        // 1: host0 write to RAM.
        set_host(0, 32'h0010_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
        do_cycle("wr_ram");
        bus.host_req[0] = 1'b0;
        do_cycle("wr_ram_rsp", 1'b1, $urandom, 1'b0);

        // 2: host0 timer read.
        set_host(0, 32'h0003_0004, 1'b0, 4'hF, $urandom);
        do_cycle("rd_tmr");
        bus.host_req[0] = 1'b0;
        do_cycle("rd_tmr_rsp", 1'b1, 32'h1234_5678, 1'b0);

        // 3: simultaneous requests; host1 waits a cycle.
        set_host(0, 32'h0002_0000, 1'b0, 4'hF, $urandom);
        set_host(1, 32'h0004_0000, 1'b1, 4'h3, $urandom);
        do_cycle("both");
        bus.host_req[0] = 1'b0;
        do_cycle("both_h1");
        bus.host_req[1] = 1'b0;
        do_cycle("both_rsp1");

        // 4: unmapped access from host1.
        set_host(1, 32'h0005_0000, 1'b0, 4'hF, $urandom);
        do_cycle("unmap");
        bus.host_req[1] = 1'b0;
        do_cycle("unmap_rsp");

        // 5: device error propagates.
        set_host(0, 32'h0003_0008, 1'b0, 4'hF, $urandom);
        do_cycle("tmr_err");
        bus.host_req[0] = 1'b0;
        do_cycle("tmr_err_rsp", 1'b1, $urandom, 1'b1);

        // 6: reset between grant and response drops the response.
        set_host(0, 32'h0010_0020, 1'b1, 4'hF, $urandom);
        do_cycle("pre_rst");
        bus.host_req[0] = 1'b0;
        rst = 1'b1;
        do_cycle("mid_rst");
        rst = 1'b0;
        do_cycle("post_rst");
        set_host(0, 32'h0004_0010, 1'b0, 4'hF, $urandom);
        do_cycle("after_rst");
        bus.host_req[0] = 1'b0;
        do_cycle("after_rst_rsp");

        // Overlapping regions: timer (2) and a moved SA region (3) both hit.
        base[3] = 32'h0003_0000;
        set_host(1, 32'h0003_0010, 1'b0, 4'hF, $urandom);
        do_cycle("overlap");
        bus.host_req[1] = 1'b0;
        do_cycle("overlap_rsp");
        base[3] = 32'h0004_0000;

        // Random traffic; a loser keeps its request until granted.
        for (int c = 0; c < 300; c++) begin
            for (int h = 0; h < NH; h++) begin
                if (!bus.host_req[h] && $urandom_range(0, 2) != 0) begin
                    set_host(h, rand_addr(), 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
                end
            end
            rst = ($urandom_range(0, 40) == 0);
            do_cycle("rand");
            if (prev_valid) bus.host_req[prev_host] = 1'b0;
        end
        rst = 1'b0;
        bus.host_req = '0;
        do_cycle("drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_bus_xbar.md
Name: mem_bus_xbar

Overview:
- Shared-bus interconnect for the Ibex simple system.
- Connects NrHosts request/grant/rvalid hosts (Ibex data port, systolic-array DMA master) to NrDevices memory-mapped devices (RAM, sim control, timer, SA config).
- Fixed-priority arbitration, base/mask address decode, one-cycle registered response routing.

Parameters:
- NrDevices, 4, number of device ports.
- NrHosts, 2, number of host ports; index 0 has highest priority.
- DataWidth, 32, data bus width.
- AddressWidth, 32, address bus width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- host_req_i  in  [NrHosts] x 1  request.
- host_gnt_o  out  [NrHosts] x 1  grant.
- host_addr_i  in  [NrHosts] x AddressWidth  byte address.
- host_we_i  in  [NrHosts] x 1  write enable.
- host_be_i  in  [NrHosts] x DataWidth/8  byte enables.
- host_wdata_i  in  [NrHosts] x DataWidth  write data.
- host_rvalid_o  out  [NrHosts] x 1  response valid.
- host_rdata_o  out  [NrHosts] x DataWidth  read data.
- host_err_o  out  [NrHosts] x 1  response error.
- device_req_o  out  [NrDevices] x 1  device request.
- device_addr_o, device_we_o, device_be_o, device_wdata_o  out  [NrDevices] x (AddressWidth / 1 / DataWidth/8 / DataWidth)  broadcast request fields.
- device_rvalid_i, device_rdata_i, device_err_i  in  [NrDevices] x (1 / DataWidth / 1)  device response.
- cfg_device_addr_base  in  [NrDevices] x AddressWidth  region base.
- cfg_device_addr_mask  in  [NrDevices] x AddressWidth  region mask.

Behaviour:
- Arbitration (combinational):
  - Winner is the lowest-index host with host_req_i=1.
  - host_gnt_o=1 for the winner only, in the same cycle.
  - Losers hold their request until granted.
- Decode (combinational, on the winner's address):
  - Device d matches when (addr & mask[d]) == base[d].
  - If regions overlap, the lowest matching index wins.
  - No match means the access is unmapped.
- Device side:
  - device_req_o[d]=1 only for the decoded device of a granted request.
  - device_addr/we/be/wdata carry the winner's fields to all devices.
  - When no host requests, these fields carry host 0's fields.
  - An unmapped request still receives a grant, but no device_req_o is raised.
- Response:
  - On a grant, register host_sel, dev_sel, unmapped flag and pending=1; pending=0 when there is no grant.
  - Devices answer exactly one cycle after their request.
  - In cycle N+1 after a cycle-N grant:
    - host_rvalid_o[host_sel] = device_rvalid_i[dev_sel].
    - rdata and err are routed from dev_sel.
    - If unmapped: rvalid=1, err=1, rdata=0.
  - Non-selected hosts see rvalid=0, err=0, rdata=0.
- Back-to-back: a new grant may occur in the same cycle as the previous response; one cycle of throughput per transaction.
- Reset:
  - While rst_i=1, all registers clear (pending=0, sel=0).
  - host_gnt_o, device_req_o and all host responses are forced to 0.
  - Reset asserted mid-transaction drops the pending response; no rvalid is issued after release.
- No combinational path from device response inputs to grant or request outputs.

Decomposition:
- Package mem_bus_pkg holds default widths and the helper function for host/device index width: $clog2 with a minimum of 1.
- One natural sub-module, mem_bus_prio_arb: parameterized fixed-priority arbiter producing a one-hot grant and a binary index.

Test Plan:
1. Map: RAM 0x100000 / ~0xFFFFF, SimCtrl 0x20000 / ~0x3FF, Timer 0x30000 / ~0x3FF, SA 0x40000 / ~0x3FF. Host0 writes 0xDEADBEEF to 0x100010, be=0xF -> same cycle gnt[0]=1, device_req[0]=1, addr 0x100010. Next cycle host_rvalid[0]=1, err=0.
2. Host0 reads 0x30004; timer returns rdata 0x12345678 with rvalid one cycle later -> host_rdata[0]=0x12345678, host_rvalid[0]=1; host1 sees rvalid=0.
3. Hosts 0 and 1 request in the same cycle (0x20000 and 0x40000) -> gnt[0]=1, gnt[1]=0. Next cycle host1 is granted, device_req[3]=1. Responses arrive in order to host0 then host1.
4. Host1 accesses 0x50000 (unmapped) -> gnt[1]=1, no device_req. Next cycle host_rvalid[1]=1, host_err[1]=1, host_rdata[1]=0.
5. Timer drives device_err=1 on a read -> host_err[0]=1 with rvalid=1.
6. Assert rst_i the cycle after a grant -> no host_rvalid. After release, a new grant works normally.
